// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock)
// with a start/busy/done handshake and a registered BCD result.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
  function automatic bit digits_ok(input int w, input int d);
    longint max_val;
    longint pow10;
    max_val = (longint'(1) << w) - 1;
    pow10   = 1;
    for (int i = 0; i < d; i++) begin
      if (pow10 <= max_val) pow10 = pow10 * 10;
    end
    return pow10 > max_val;
  endfunction

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "bin_to_bcd_seq: WIDTH must be at least 1");
  end
  if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
    $fatal(1, "bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  logic [1:0]          state;
  logic [WIDTH-1:0]    shreg;
  logic [4*DIGITS-1:0] scratch;
  logic [CW-1:0]       cnt;

  logic [4*DIGITS-1:0] corrected;
  logic [4*DIGITS-1:0] scratch_nx;
  logic [WIDTH-1:0]    shreg_nx;

  // Add-3 correction on each digit, then one combined left shift.
  always_comb begin
    corrected = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) corrected[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
    {scratch_nx, shreg_nx} = {corrected[4*DIGITS-2:0], shreg, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          shreg   <= shreg_nx;
          scratch <= scratch_nx;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd   <= scratch_nx;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule
